// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral serving a local byte-wide register file.
// Frame (MSB first): address, R/W bit (1 = read), then 8 data bits.
// Optional burst mode: define SPI_PERIPH_AUTOINC_EN. Extra data bytes in the
// same chip-select window then go to consecutive (wrapping) addresses.
module spi_peripheral #(
  parameter int ADDR_WIDTH  = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk_in,
  input  logic cs_in,
  input  logic mosi_in,
  output logic miso_out,
  output logic miso_oe,
  output logic frame_done,
  output logic frame_rw
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = $clog2(((ADDR_WIDTH > 8) ? ADDR_WIDTH : 8) + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, RD_LOAD, RD_SHIFT, WR_SHIFT, COMMIT, WAIT_CS
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic sclk_prev_q, cs_prev_q, sclk_rise_q, sclk_fall_q, cs_fall_q;
  logic sclk_s, cs_s, mosi_s;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic [7:0]            rx_q, rx_d, tx_q, tx_d;
  logic                  miso_q, miso_d, oe_q, oe_d;
  logic                  done_q, done_d, frame_rw_q, frame_rw_d;
  logic                  rdpend_q, rdpend_d;
  logic                  mem_we;
  logic [7:0]            mem_rd;
  logic [7:0]            mem_q [DEPTH];

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign mem_rd = mem_q[addr_q];

  // Synchronise the asynchronous SPI pins and derive registered edge pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_fall_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_in};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      sclk_rise_q <= sclk_s & ~sclk_prev_q;
      sclk_fall_q <= ~sclk_s & sclk_prev_q;
      cs_fall_q   <= ~cs_s & cs_prev_q;
    end
  end

  // Frame decoder: next-state and datapath updates; a high chip select aborts.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    done_d     = 1'b0;
    frame_rw_d = frame_rw_q;
    rdpend_d   = rdpend_q;
    mem_we     = 1'b0;
    if (state_q != IDLE && cs_s) begin
      state_d  = IDLE;
      cnt_d    = '0;
      oe_d     = 1'b0;
      miso_d   = 1'b0;
      rdpend_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall_q) begin
            state_d = ADDR;
            cnt_d   = '0;
          end
        end
        ADDR: begin
          if (sclk_rise_q) begin
            if (cnt_q == CNT_W'(ADDR_WIDTH)) begin
              rw_d    = mosi_s;
              cnt_d   = '0;
              state_d = mosi_s ? RD_LOAD : WR_SHIFT;
            end else begin
              addr_d = {addr_q[ADDR_WIDTH-2:0], mosi_s};
              cnt_d  = cnt_q + 1'b1;
            end
          end
        end
        RD_LOAD: begin
          // A burst continuation arrives on the falling edge itself, so D7
          // must go out immediately instead of waiting for the next fall.
          oe_d     = 1'b1;
          cnt_d    = '0;
          rdpend_d = 1'b0;
          if (rdpend_q) begin
            miso_d = mem_rd[7];
            tx_d   = {mem_rd[6:0], 1'b0};
          end else begin
            tx_d = mem_rd;
          end
          state_d = RD_SHIFT;
        end
        RD_SHIFT: begin
          if (sclk_fall_q) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
          if (sclk_rise_q) begin
            if (cnt_q == CNT_W'(7)) begin
              cnt_d   = '0;
              state_d = COMMIT;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        WR_SHIFT: begin
          if (sclk_rise_q) begin
            rx_d = {rx_q[6:0], mosi_s};
            if (cnt_q == CNT_W'(7)) begin
              cnt_d   = '0;
              state_d = COMMIT;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        COMMIT: begin
          mem_we     = ~rw_q;
          done_d     = 1'b1;
          frame_rw_d = rw_q;
          state_d    = WAIT_CS;
`ifdef SPI_PERIPH_AUTOINC_EN
          if (!rw_q) begin
            oe_d   = 1'b0;
            miso_d = 1'b0;
          end
`else
          oe_d   = 1'b0;
          miso_d = 1'b0;
`endif
        end
        WAIT_CS: begin
`ifdef SPI_PERIPH_AUTOINC_EN
          if (rw_q && sclk_fall_q) begin
            addr_d   = addr_q + 1'b1;
            rdpend_d = 1'b1;
            state_d  = RD_LOAD;
          end else if (!rw_q && sclk_rise_q) begin
            addr_d  = addr_q + 1'b1;
            rx_d    = {rx_q[6:0], mosi_s};
            cnt_d   = CNT_W'(1);
            state_d = WR_SHIFT;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and shift registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      rx_q       <= '0;
      tx_q       <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
      frame_rw_q <= 1'b0;
      rdpend_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      done_q     <= done_d;
      frame_rw_q <= frame_rw_d;
      rdpend_q   <= rdpend_d;
    end
  end

  // Register file write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[addr_q] <= rx_q;
  end

  assign miso_out   = miso_q & oe_q;
  assign miso_oe    = oe_q;
  assign frame_done = done_q;
  assign frame_rw   = frame_rw_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: acts as the SPI controller and checks
// register contents by reading them back over the link.
module tb_spi_peripheral;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sclk_in = 1'b0;
  logic cs_in = 1'b1;
  logic mosi_in = 1'b0;
  logic miso_out, miso_oe, frame_done, frame_rw;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  spi_peripheral #(.ADDR_WIDTH(7), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sclk_in(sclk_in), .cs_in(cs_in),
    .mosi_in(mosi_in), .miso_out(miso_out), .miso_oe(miso_oe),
    .frame_done(frame_done), .frame_rw(frame_rw)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done) done_cnt <= done_cnt + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one chip-select window; stop_at >= 0 cuts the frame before that bit.
  task automatic spi_xfer(input int nbits, input logic [23:0] pat, input int stop_at,
                          input bit raise_cs, output logic [15:0] rd,
                          output bit oe_ok, output int lat);
    rd = '0; oe_ok = 1'b1; lat = 0;
    @(negedge clk);
    cs_in = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == stop_at) break;
      mosi_in = pat[nbits-1-i];
      repeat (HALF) @(negedge clk);
      if (i >= 8) begin
        rd = {rd[14:0], miso_out};
        if (miso_oe !== 1'b1) oe_ok = 1'b0;
      end
      sclk_in = 1'b1;
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clk);
        if (frame_done === 1'b1 && lat == 0) lat = k;
      end
      sclk_in = 1'b0;
    end
    if (raise_cs) begin
      repeat (HALF) @(negedge clk);
      cs_in = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d, input string tag,
                          output int lat);
    logic [15:0] rd; bit ok; int d0;
    d0 = done_cnt;
    spi_xfer(16, {8'h00, a, 1'b0, d}, -1, 1'b1, rd, ok, lat);
    chk({tag, "_done"}, done_cnt - d0, 1);
    chk({tag, "_rw"}, frame_rw, 1'b0);
  endtask

  task automatic do_read(input logic [6:0] a, input logic [7:0] exp, input string tag);
    logic [15:0] rd; bit ok; int lat, d0;
    logic [7:0] want;
    exp_q.push_back(exp);
    d0 = done_cnt;
    spi_xfer(16, {8'h00, a, 1'b1, 8'h00}, -1, 1'b1, rd, ok, lat);
    want = exp_q.pop_front();
    chk({tag, "_data"}, rd[7:0], want);
    chk({tag, "_oe_during"}, ok, 1'b1);
    chk({tag, "_done"}, done_cnt - d0, 1);
    chk({tag, "_rw"}, frame_rw, 1'b1);
    chk({tag, "_oe_after"}, miso_oe, 1'b0);
  endtask

  initial begin
    logic [15:0] rd; bit ok; int lat, d0;
    logic [6:0] ra; logic [7:0] rdat;

    // reset state
    repeat (4) @(negedge clk);
    chk("rst_oe", miso_oe, 1'b0);
    chk("rst_miso", miso_out, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_rw", frame_rw, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_oe", miso_oe, 1'b0);

    // 1: write A5 to 0x05, frame_done 5 clk after final SCLK rise
    do_write(7'h05, 8'hA5, "wr05", lat);
    chk("wr05_latency", lat, 5);
    chk("wr05_oe", miso_oe, 1'b0);

    // 2: read it back (bits 1,0,1,0,0,1,0,1)
    do_read(7'h05, 8'hA5, "rd05");

    // 3: abort a write after 4 data bits
    do_write(7'h10, 8'h5A, "wr10", lat);
    d0 = done_cnt;
    spi_xfer(16, {8'h00, 7'h10, 1'b0, 8'h3C}, 12, 1'b1, rd, ok, lat);
    chk("abort_done", done_cnt - d0, 0);
    chk("abort_oe", miso_oe, 1'b0);
    do_read(7'h10, 8'h5A, "rd10_after_abort");

    // 4: reset in the middle of a read data phase
    d0 = done_cnt;
    spi_xfer(16, {8'h00, 7'h05, 1'b1, 8'h00}, 11, 1'b0, rd, ok, lat);
    repeat (4) @(negedge clk);
    chk("midrd_oe", miso_oe, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrd_rst_oe", miso_oe, 1'b0);
    chk("midrd_rst_miso", miso_out, 1'b0);
    repeat (HALF) @(negedge clk);
    cs_in = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    chk("midrd_no_done", done_cnt - d0, 0);
    do_read(7'h05, 8'hA5, "rd05_after_rst");

    // 5/6: 0x7F then a second byte in one chip-select window
    do_write(7'h00, 8'h99, "wr00", lat);
    d0 = done_cnt;
    spi_xfer(24, {7'h7F, 1'b0, 8'h11, 8'h22}, -1, 1'b1, rd, ok, lat);
`ifdef SPI_PERIPH_AUTOINC_EN
    chk("burst_done", done_cnt - d0, 2);
    do_read(7'h7F, 8'h11, "rd7f");
    do_read(7'h00, 8'h22, "rd00_wrap");
`else
    chk("burst_done", done_cnt - d0, 1);
    do_read(7'h7F, 8'h11, "rd7f");
    do_read(7'h00, 8'h99, "rd00_kept");
`endif

    // assorted address/data patterns
    for (int n = 0; n < 3; n++) begin
      ra = 7'($urandom_range(32, 100));
      rdat = 8'($urandom);
      do_write(ra, rdat, "wr_rand", lat);
      do_read(ra, rdat, "rd_rand");
    end
    do_write(7'h2A, 8'h00, "wr2a_zero", lat);
    do_read(7'h2A, 8'h00, "rd2a_zero");
    do_write(7'h2A, 8'hFF, "wr2a_ones", lat);
    do_read(7'h2A, 8'hFF, "rd2a_ones");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
